// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: sequences fixed-latency mult/div operations
// and owns the architectural HI/LO registers, raising stall to the D/E stages.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        commit_en;
    logic [31:0] res_hi_p0;
    logic [31:0] res_lo_p0;
    logic        accept;
    logic        md_op;

    // Full 64-bit product; sign-extending to 64 bits makes the low half exact.
    function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
        logic signed [63:0] ax;
        logic signed [63:0] bx;
        ax = {{32{sgn & a[31]}}, a};
        bx = {{32{sgn & b[31]}}, b};
        return 64'(ax * bx);
    endfunction

    // Returns {remainder, quotient}; magnitude division keeps MIN/-1 well defined.
    function automatic logic [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
        logic        na;
        logic        nb;
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        na = sgn & a[31];
        nb = sgn & b[31];
        ua = na ? -a : a;
        ub = nb ? -b : b;
        if (ub == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (na ^ nb) q = -q;
        if (na)      r = -r;
        return {r, q};
    endfunction

    assign accept = start & ~flush & (state == IDLE);
    assign md_op  = (op >= 3'd1) && (op <= 3'd4);
    assign busy   = (state != IDLE);
    assign stall  = md_use & ~rst & (busy | (start & ~flush & md_op));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            commit_en <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            3'd1, 3'd2: begin
                                state     <= MUL;
                                cnt       <= 4'(MULT_CYCLES);
                                commit_en <= 1'b1;
                            end
                            3'd3, 3'd4: begin
                                state     <= DIV;
                                cnt       <= 4'(DIV_CYCLES);
                                commit_en <= (B != 32'd0);
                            end
                            3'd5:    hi <= A;
                            3'd6:    lo <= A;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                        if (commit_en) begin
                            hi <= res_hi_p0;
                            lo <= res_lo_p0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    // Stage p0: operand-derived result captured once at the accepting edge.
    always_ff @(posedge clk) begin
        if (accept && md_op) begin
            if (op <= 3'd2)
                {res_hi_p0, res_lo_p0} <= mul_full(A, B, op == 3'd1);
            else
                {res_hi_p0, res_lo_p0} <= div_full(A, B, op == 3'd3);
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO and busy length are queued at
// issue and compared when busy drops.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        md_use = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy, stall;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
        .A(A), .B(B), .md_use(md_use), .busy(busy), .stall(stall),
        .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          ncyc;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        prev_busy = 1'b0;
    int          bcnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        case (o)
            3'd1: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                return p;
            end
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) return {m_hi, m_lo};
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {m_hi, m_lo};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // One cycle: advance to the falling edge, then score any commit.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (busy) begin
            bcnt++;
        end else if (prev_busy) begin
            if (sbq.size() == 0) begin
                check("spurious_commit", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                check("commit_hi", {32'd0, hi}, {32'd0, e.hi});
                check("commit_lo", {32'd0, lo}, {32'd0, e.lo});
                check("busy_cycles", 64'(bcnt), 64'(e.ncyc));
            end
            bcnt = 0;
        end
        prev_busy = busy;
    endtask

    task automatic push_exp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] r;
        r      = model(o, a, b);
        e.hi   = r[63:32];
        e.lo   = r[31:0];
        e.ncyc = (o <= 3'd2) ? 5 : 10;
        m_hi   = e.hi;
        m_lo   = e.lo;
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (o >= 3'd1 && o <= 3'd4) push_exp(o, a, b);
        tick();
        start = 1'b0;
        op    = 3'd0;
        if (o == 3'd5) begin
            m_hi = a;
            check("mthi_hi", {32'd0, hi}, {32'd0, m_hi});
            check("mthi_busy", {63'd0, busy}, 64'd0);
        end
        if (o == 3'd6) begin
            m_lo = a;
            check("mtlo_lo", {32'd0, lo}, {32'd0, m_lo});
            check("mtlo_busy", {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || sbq.size() != 0) && k < 100) begin
            tick();
            k++;
        end
        check("idle_timeout", {63'd0, k >= 100}, 64'd0);
    endtask

    initial begin
        start  = 1'b1;
        op     = 3'd1;
        md_use = 1'b1;
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        rst    = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        md_use = 1'b0;

        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002); wait_idle();
        issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002); wait_idle();
        issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002); wait_idle();
        issue(3'd4, 32'd7, 32'd0);                 wait_idle();
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        issue(3'd3, 32'h0000_0011, 32'hFFFF_FFFB); wait_idle();
        issue(3'd3, 32'h1234_5678, 32'd0);         wait_idle();

        // Flushed start must be dropped entirely.
        md_use = 1'b1;
        start  = 1'b1; flush = 1'b1; op = 3'd1; A = 32'd3; B = 32'd4;
        #1 check("flush_stall", {63'd0, stall}, 64'd0);
        tick();
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_hi", {32'd0, hi}, {32'd0, m_hi});
        check("flush_lo", {32'd0, lo}, {32'd0, m_lo});
        start = 1'b0; flush = 1'b0; op = 3'd0; md_use = 1'b0;

        // Second start, operand change and flush while busy are all ignored.
        issue(3'd2, 32'h0001_0003, 32'h0002_0005);
        start = 1'b1; op = 3'd3; A = 32'd99; B = 32'd3;
        tick();
        start = 1'b0; op = 3'd0; A = 32'hDEAD_BEEF; B = 32'h1; flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle();

        // Stall across a divide.
        md_use = 1'b1;
        start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
        push_exp(3'd3, 32'd100, 32'd7);
        #1 check("stall_issue", {63'd0, stall}, 64'd1);
        tick();
        start = 1'b0; op = 3'd0;
        for (int i = 0; i < 10; i++) begin
            check("stall_busy", {63'd0, stall}, 64'd1);
            tick();
        end
        check("stall_after", {63'd0, stall}, 64'd0);
        md_use = 1'b0;
        wait_idle();

        issue(3'd5, 32'h1234_5678, 32'd0);
        issue(3'd6, 32'hCAFE_F00D, 32'd0);

        // Asynchronous reset in busy cycle 3 of a multiply.
        issue(3'd1, 32'h0000_1234, 32'h0000_5678);
        tick();
        tick();
        md_use = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_hi", {32'd0, hi}, 64'd0);
        check("arst_lo", {32'd0, lo}, 64'd0);
        check("arst_stall", {63'd0, stall}, 64'd0);
        #1 rst = 1'b0;
        md_use = 1'b0;
        sbq.delete();
        m_hi = 32'd0; m_lo = 32'd0; prev_busy = 1'b0; bcnt = 0;
        repeat (8) tick();
        check("arst_no_commit_hi", {32'd0, hi}, 64'd0);
        check("arst_no_commit_lo", {32'd0, lo}, 64'd0);
        issue(3'd2, 32'h8000_0001, 32'h0000_0003); wait_idle();

        for (int i = 0; i < 8; i++) begin
            logic [2:0] o;
            o = 3'($urandom_range(1, 4));
            issue(o, $urandom, (i == 5) ? 32'd0 : $urandom);
            wait_idle();
        end

        check("queue_empty", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration of mult/multu in cycles (legal range 1-15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration of div/divu in cycles (legal range 1-15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  E-stage MD instruction issue strobe.
REQ-006 SHALL have port op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 treated as none.
REQ-007 SHALL have port flush  input  1  exception/interrupt in M stage; cancels a same-cycle start.
REQ-008 SHALL have ports A and B  input  32 each  operands: rs and rt value in E stage.
REQ-009 SHALL have port md_use  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port busy  output  1  unit is computing.
REQ-011 SHALL have port stall  output  1  stall request to the D/E pipeline registers.
REQ-012 SHALL have ports hi and lo  output  32 each  architectural HI/LO (registered).

Function
REQ-013 SHALL implement states IDLE, MUL, DIV; busy=1 exactly in MUL or DIV.
REQ-014 An accepted start is start=1 & flush=0 & state=IDLE & op in 1..6; all other starts SHALL be ignored with no state change.
REQ-015 Accepted op 1/2 at edge T SHALL enter MUL, load counter with MULT_CYCLES, latch the 64-bit product: signed for op 1, unsigned for op 2.
REQ-016 Accepted op 3/4 at edge T SHALL enter DIV, load counter with DIV_CYCLES, latch quotient and remainder: signed for op 3, unsigned for op 4.
REQ-017 Counter SHALL decrement each edge in MUL/DIV; the edge where counter=1 SHALL return to IDLE and commit results.
REQ-018 busy SHALL be high for exactly N cycles after edge T (N = MULT_CYCLES or DIV_CYCLES); hi/lo SHALL change only at edge T+N.
REQ-019 Mult commit SHALL write hi=product[63:32] and lo=product[31:0].
REQ-020 Div commit SHALL write lo=quotient and hi=remainder.
REQ-021 Signed division SHALL truncate the quotient toward zero; the remainder SHALL take the dividend's sign.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL commit lo=0x80000000, hi=0x00000000.
REQ-023 Division with B=0 SHALL still run DIV_CYCLES and SHALL leave hi/lo unchanged at commit.
REQ-024 Accepted op 5 SHALL write hi=A and accepted op 6 SHALL write lo=A at edge T, with no busy cycle.
REQ-025 stall SHALL equal md_use & (busy | (start & ~flush & op in 1..4)); it is combinational from registered state and inputs.
REQ-026 flush while busy SHALL NOT abort the operation; the commit still occurs.
REQ-027 Operands SHALL be sampled only at the accepting edge; A/B changes during busy SHALL have no effect.

Reset
REQ-028 rst=1 SHALL immediately, without clk, force state=IDLE, counter=0, busy=0, hi=0, lo=0, and discard pending results.
REQ-029 rst asserted mid-MUL/DIV SHALL abort the operation; after release no commit SHALL occur and the first accepted start SHALL behave as from a fresh reset.
REQ-030 stall SHALL be 0 during reset regardless of md_use.

Verification
REQ-031 mult A=0xFFFFFFFF B=0x00000002 -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-032 multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
REQ-033 div A=-7 B=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7 B=0 -> busy for 10 cycles, hi/lo unchanged.
REQ-034 start=1 with flush=1 and op=mult -> busy stays 0, hi/lo unchanged, stall=0. A second start during busy -> ignored, first result intact.
REQ-035 md_use=1 through a div -> stall=1 on the issue cycle and all 10 busy cycles, 0 the cycle after. mthi A=0x12345678 -> hi=0x12345678 next edge, busy=0.
REQ-036 rst pulsed between clk edges at busy cycle 3 of a mult -> busy=0, hi=lo=0 immediately, no later commit.
